// File: rtl/cp0_pkg.sv
// CP0 register-file constants shared by the register file and its timer.
// Register indices, ExcCode values, and the Status stack shift width.
package cp0_pkg;

    // CP0 register indices as seen on the rd bus
    localparam logic [4:0] CP0_COUNT   = 5'd9;
    localparam logic [4:0] CP0_COMPARE = 5'd11;
    localparam logic [4:0] CP0_STATUS  = 5'd12;
    localparam logic [4:0] CP0_CAUSE   = 5'd13;
    localparam logic [4:0] CP0_EPC     = 5'd14;

    // ExcCode values the core presents on the cause bus
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    // Status acts as a stack of 5-bit mode fields: push on exception, pop on eret
    localparam int STATUS_SHIFT = 5;

    // Assemble the architectural Cause word; every unlisted bit reads 0
    function automatic logic [31:0] cause_word(input logic       ip7,
                                               input logic [1:0] sw_ip,
                                               input logic [4:0] exc_code);
        return {16'h0000, ip7, 5'b00000, sw_ip, 1'b0, exc_code, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with the IP7 pending flag.
// Count free-runs and wraps; a write to Count loads it instead of incrementing.
// IP7 sets when the updated Count equals the updated Compare and is cleared by a
// write to Compare; a clear on the same edge as a set wins.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ip7
);

    logic [31:0] count_next;
    logic [31:0] compare_next;

    assign count_next   = count_we   ? wdata : count + 32'd1;
    assign compare_next = compare_we ? wdata : compare;

    // Advance Count, hold/load Compare, and track the match flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            compare <= '0;
            ip7     <= 1'b0;
        end else begin
            count   <= count_next;
            compare <= compare_next;
            if (compare_we)
                ip7 <= 1'b0;
            else if (count_next == compare_next)
                ip7 <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: mfc0/mtc0 access, exception entry and eret.
// Holds Status, Cause (software IP and ExcCode fields) and EPC; supplies the
// PC redirect target on exc_addr. Event priority: exception > eret > mtc0.
// Optional build macro CP0_TIMER_EN adds Count/Compare and the timer interrupt;
// without it Count/Compare read 0, Cause[15] is 0 and intr is tied low.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0004,
    parameter logic [31:0] STATUS_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mfc0,
    input  logic        mtc0,
    input  logic [31:0] pc,
    input  logic [4:0]  rd,
    input  logic [31:0] wdata,
    input  logic        exception,
    input  logic        eret,
    input  logic [4:0]  cause,
    output logic [31:0] rdata,
    output logic [31:0] status,
    output logic [31:0] exc_addr,
    output logic        intr
);

    logic [31:0] status_q;
    logic [31:0] epc_q;
    logic [1:0]  sw_ip_q;
    logic [4:0]  exc_code_q;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ip7;
    logic        mtc0_win;
    logic [31:0] cause_q;

    // A write only lands when no exception or eret claims the same edge
    assign mtc0_win = mtc0 & ~exception & ~eret;
    assign cause_q  = cause_word(ip7, sw_ip_q, exc_code_q);
    assign status   = status_q;
    assign exc_addr = eret ? epc_q : EXC_VECTOR;

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .count_we   (mtc0_win && (rd == CP0_COUNT)),
        .compare_we (mtc0_win && (rd == CP0_COMPARE)),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ip7        (ip7)
    );

    assign intr = status_q[0] & status_q[15] & ip7;
`else
    assign count   = '0;
    assign compare = '0;
    assign ip7     = 1'b0;
    assign intr    = 1'b0;
`endif

    // Status/Cause/EPC update with exception > eret > mtc0 priority
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_q   <= STATUS_RESET;
            epc_q      <= '0;
            sw_ip_q    <= '0;
            exc_code_q <= '0;
        end else if (exception) begin
            epc_q      <= pc;
            exc_code_q <= cause;
            status_q   <= {status_q[31-STATUS_SHIFT:0], {STATUS_SHIFT{1'b0}}};
        end else if (eret) begin
            status_q   <= {{STATUS_SHIFT{1'b0}}, status_q[31:STATUS_SHIFT]};
        end else if (mtc0_win) begin
            case (rd)
                CP0_STATUS: status_q <= wdata;
                CP0_EPC:    epc_q    <= wdata;
                CP0_CAUSE:  sw_ip_q  <= wdata[9:8];
                default:    ;
            endcase
        end
    end

    // Zero-latency read mux; reads show pre-edge values
    // NOTE: rdata gets a default before the case so no path infers a latch.
    always_comb begin
        rdata = '0;
        if (mfc0) begin
            case (rd)
                CP0_COUNT:   rdata = count;
                CP0_COMPARE: rdata = compare;
                CP0_STATUS:  rdata = status_q;
                CP0_CAUSE:   rdata = cause_q;
                CP0_EPC:     rdata = epc_q;
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed testbench for cp0_regfile. Inputs change 1 time unit after the rising
// edge; outputs are sampled mid-cycle, away from the edge.
module tb_cp0_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        mfc0;
    logic        mtc0;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        exception;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] rdata;
    logic [31:0] status;
    logic [31:0] exc_addr;
    logic        intr;

    int passed = 0;
    int total  = 0;

    cp0_regfile #(
        .EXC_VECTOR   (32'h0000_0004),
        .STATUS_RESET (32'h0000_0000)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mfc0      (mfc0),
        .mtc0      (mtc0),
        .pc        (pc),
        .rd        (rd),
        .wdata     (wdata),
        .exception (exception),
        .eret      (eret),
        .cause     (cause),
        .rdata     (rdata),
        .status    (status),
        .exc_addr  (exc_addr),
        .intr      (intr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] idx, input logic [31:0] data);
        mtc0  = 1'b1;
        rd    = idx;
        wdata = data;
        tick();
        mtc0  = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] idx, output logic [31:0] data);
        mfc0 = 1'b1;
        rd   = idx;
        #1;
        data = rdata;
        mfc0 = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b0;
        mfc0 = 0; mtc0 = 0; pc = '0; rd = '0; wdata = '0;
        exception = 0; eret = 0; cause = '0;
        #1;
        total++; if (status !== 32'h0) $display("FAIL reset_status got=%h exp=%h", status, 32'h0); else passed++;
        total++; if (exc_addr !== 32'h4) $display("FAIL reset_exc_addr got=%h exp=%h", exc_addr, 32'h4); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); else passed++;
        total++; if (intr !== 1'b0) $display("FAIL reset_intr got=%b exp=0", intr); else passed++;
        #3;
        reset = 1'b1;
        tick();
        // Mid-run async reset with Status loaded
        write_reg(5'd12, 32'h0000_1234);
        read_reg(5'd12, v);
        total++; if (v !== 32'h0000_1234) $display("FAIL status_load got=%h exp=%h", v, 32'h0000_1234); else passed++;
        mfc0 = 1'b1;
        rd   = 5'd12;
        #2;
        reset = 1'b0;
        #1;
        total++; if (status !== 32'h0) $display("FAIL async_reset_status got=%h exp=%h", status, 32'h0); else passed++;
        total++; if (rdata !== 32'h0) $display("FAIL async_reset_rdata got=%h exp=%h", rdata, 32'h0); else passed++;
        mfc0 = 1'b0;
        #1;
        reset = 1'b1;
        tick();
    endtask

    task automatic test_epc_rw();
        logic [31:0] v;
        write_reg(5'd14, 32'hBFC0_0100);
        read_reg(5'd14, v);
        total++; if (v !== 32'hBFC0_0100) $display("FAIL epc_rw got=%h exp=%h", v, 32'hBFC0_0100); else passed++;
        rd = 5'd14;
        #1;
        total++; if (rdata !== 32'h0) $display("FAIL rdata_idle got=%h exp=%h", rdata, 32'h0); else passed++;
        write_reg(5'd3, 32'hDEAD_BEEF);
        read_reg(5'd3, v);
        total++; if (v !== 32'h0) $display("FAIL unimpl_reg got=%h exp=%h", v, 32'h0); else passed++;
    endtask

    task automatic test_read_during_write();
        write_reg(5'd12, 32'h0000_0055);
        mtc0  = 1'b1;
        mfc0  = 1'b1;
        rd    = 5'd12;
        wdata = 32'h0000_00AA;
        #1;
        total++; if (rdata !== 32'h0000_0055) $display("FAIL rdw_old got=%h exp=%h", rdata, 32'h0000_0055); else passed++;
        tick();
        mtc0 = 1'b0;
        #1;
        total++; if (rdata !== 32'h0000_00AA) $display("FAIL rdw_new got=%h exp=%h", rdata, 32'h0000_00AA); else passed++;
        mfc0 = 1'b0;
    endtask

    task automatic test_exception_eret();
        logic [31:0] v;
        write_reg(5'd12, 32'h0000_001F);
        exception = 1'b1;
        cause     = 5'd8;
        pc        = 32'h0040_0010;
        #1;
        total++; if (exc_addr !== 32'h4) $display("FAIL exc_vector got=%h exp=%h", exc_addr, 32'h4); else passed++;
        tick();
        exception = 1'b0;
        read_reg(5'd14, v);
        total++; if (v !== 32'h0040_0010) $display("FAIL exc_epc got=%h exp=%h", v, 32'h0040_0010); else passed++;
        read_reg(5'd13, v);
        total++; if (v !== 32'h0000_0020) $display("FAIL exc_cause got=%h exp=%h", v, 32'h0000_0020); else passed++;
        total++; if (status !== 32'h0000_03E0) $display("FAIL exc_status got=%h exp=%h", status, 32'h0000_03E0); else passed++;
        eret = 1'b1;
        #1;
        total++; if (exc_addr !== 32'h0040_0010) $display("FAIL eret_addr got=%h exp=%h", exc_addr, 32'h0040_0010); else passed++;
        tick();
        eret = 1'b0;
        #1;
        total++; if (status !== 32'h0000_001F) $display("FAIL eret_status got=%h exp=%h", status, 32'h0000_001F); else passed++;
        total++; if (exc_addr !== 32'h4) $display("FAIL post_eret_addr got=%h exp=%h", exc_addr, 32'h4); else passed++;
    endtask

    task automatic test_priority();
        logic [31:0] v;
        // Exception beats mtc0 to Status
        exception = 1'b1;
        cause     = 5'd9;
        pc        = 32'h0000_0100;
        mtc0      = 1'b1;
        rd        = 5'd12;
        wdata     = 32'hFFFF_FFFF;
        tick();
        exception = 1'b0;
        mtc0      = 1'b0;
        #1;
        total++; if (status !== 32'h0000_03E0) $display("FAIL exc_vs_mtc0 got=%h exp=%h", status, 32'h0000_03E0); else passed++;
        read_reg(5'd13, v);
        total++; if (v !== 32'h0000_0024) $display("FAIL exc_vs_mtc0_cause got=%h exp=%h", v, 32'h0000_0024); else passed++;
        // Eret beats mtc0 to Status
        eret  = 1'b1;
        mtc0  = 1'b1;
        rd    = 5'd12;
        wdata = 32'hFFFF_FFFF;
        tick();
        eret = 1'b0;
        mtc0 = 1'b0;
        #1;
        total++; if (status !== 32'h0000_001F) $display("FAIL eret_vs_mtc0 got=%h exp=%h", status, 32'h0000_001F); else passed++;
        // Eret beats mtc0 to EPC
        eret  = 1'b1;
        mtc0  = 1'b1;
        rd    = 5'd14;
        wdata = 32'h1234_5678;
        tick();
        eret = 1'b0;
        mtc0 = 1'b0;
        read_reg(5'd14, v);
        total++; if (v !== 32'h0000_0100) $display("FAIL eret_vs_mtc0_epc got=%h exp=%h", v, 32'h0000_0100); else passed++;
        // Exception beats eret: left shift wins
        write_reg(5'd12, 32'h0000_0003);
        exception = 1'b1;
        eret      = 1'b1;
        cause     = 5'd13;
        pc        = 32'h0000_0200;
        tick();
        exception = 1'b0;
        eret      = 1'b0;
        #1;
        total++; if (status !== 32'h0000_0060) $display("FAIL exc_vs_eret got=%h exp=%h", status, 32'h0000_0060); else passed++;
        // Saturating push: top bits fall off
        write_reg(5'd12, 32'hF800_0001);
        exception = 1'b1;
        tick();
        exception = 1'b0;
        #1;
        total++; if (status !== 32'h0000_0020) $display("FAIL shift_out got=%h exp=%h", status, 32'h0000_0020); else passed++;
    endtask

    task automatic test_cause_write();
        logic [31:0] v;
        do_reset();
        write_reg(5'd13, 32'hFFFF_FFFF);
        read_reg(5'd13, v);
        total++; if (v !== 32'h0000_0300) $display("FAIL cause_mask got=%h exp=%h", v, 32'h0000_0300); else passed++;
        write_reg(5'd13, 32'h0000_0100);
        read_reg(5'd13, v);
        total++; if (v !== 32'h0000_0100) $display("FAIL cause_swip got=%h exp=%h", v, 32'h0000_0100); else passed++;
    endtask

    task automatic test_timer();
        logic [31:0] v;
        do_reset();
`ifdef CP0_TIMER_EN
        write_reg(5'd12, 32'h0000_8001);
        write_reg(5'd11, 32'd5);
        write_reg(5'd9, 32'd0);
        repeat (4) tick();
        read_reg(5'd13, v);
        total++; if (v[15] !== 1'b0) $display("FAIL ip7_early got=%b exp=0", v[15]); else passed++;
        total++; if (intr !== 1'b0) $display("FAIL intr_early got=%b exp=0", intr); else passed++;
        tick();
        read_reg(5'd13, v);
        total++; if (v !== 32'h0000_8000) $display("FAIL ip7_set got=%h exp=%h", v, 32'h0000_8000); else passed++;
        total++; if (intr !== 1'b1) $display("FAIL intr_set got=%b exp=1", intr); else passed++;
        write_reg(5'd11, 32'd0);
        read_reg(5'd13, v);
        total++; if (v !== 32'h0) $display("FAIL ip7_clear got=%h exp=%h", v, 32'h0); else passed++;
        total++; if (intr !== 1'b0) $display("FAIL intr_clear got=%b exp=0", intr); else passed++;
        write_reg(5'd9, 32'hFFFF_FFFF);
        tick();
        read_reg(5'd9, v);
        total++; if (v !== 32'h0) $display("FAIL count_wrap got=%h exp=%h", v, 32'h0); else passed++;
`else
        write_reg(5'd12, 32'h0000_8001);
        write_reg(5'd9, 32'h0000_0007);
        write_reg(5'd11, 32'h0000_0007);
        read_reg(5'd9, v);
        total++; if (v !== 32'h0) $display("FAIL count_absent got=%h exp=%h", v, 32'h0); else passed++;
        read_reg(5'd11, v);
        total++; if (v !== 32'h0) $display("FAIL compare_absent got=%h exp=%h", v, 32'h0); else passed++;
        repeat (8) tick();
        total++; if (intr !== 1'b0) $display("FAIL intr_absent got=%b exp=0", intr); else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_epc_rw();
        test_read_during_write();
        test_exception_eret();
        test_priority();
        test_cause_write();
        test_timer();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
